// File: rtl/regfile_sb.sv
// Parametrised register file: two registered read ports, one write port with
// optional write-to-read bypass, and a pending scoreboard. Optional: ZERO_REG_EN.
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [ADDR_W:0]   pending_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  pending_reg;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   cnt_reg;
    logic [ADDR_W:0]   cnt_next;
    logic [DATA_W-1:0] a_reg, b_reg, a_next, b_next;
    logic              rs_busy_reg, rt_busy_reg, rs_busy_next, rt_busy_next;
    logic              wr_eff, issue_eff;

`ifdef ZERO_REG_EN
    // Register 0 is a constant: neither writes nor issues may touch it.
    assign wr_eff    = wr_en && (rd != '0);
    assign issue_eff = issue_en && (issue_addr != '0);
`else
    assign wr_eff    = wr_en;
    assign issue_eff = issue_en;
`endif

    // A retiring write clears its bit, but a new issue to the same register wins.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pending
            assign pending_next[gi] = (issue_eff && issue_addr == ADDR_W'(gi)) ||
                                      (pending_reg[gi] && !(wr_eff && rd == ADDR_W'(gi)));
        end
    endgenerate

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (ADDR_W + 1)'(pending_next[i]);
        end
    end

    always_comb begin
        a_next       = mem_reg[rs];
        b_next       = mem_reg[rt];
        rs_busy_next = pending_reg[rs];
        rt_busy_next = pending_reg[rt];
        if (BYPASS != 0) begin
            if (wr_eff && rd == rs) begin
                a_next       = data_in;
                rs_busy_next = issue_eff && issue_addr == rs;
            end
            if (wr_eff && rd == rt) begin
                b_next       = data_in;
                rt_busy_next = issue_eff && issue_addr == rt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            pending_reg <= '0;
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            rs_busy_reg <= 1'b0;
            rt_busy_reg <= 1'b0;
        end else begin
            if (wr_eff) begin
                mem_reg[rd] <= data_in;
            end
            pending_reg <= pending_next;
            cnt_reg     <= cnt_next;
            if (rd_en) begin
                a_reg       <= a_next;
                b_reg       <= b_next;
                rs_busy_reg <= rs_busy_next;
                rt_busy_reg <= rt_busy_next;
            end
        end
    end

    assign A           = a_reg;
    assign B           = b_reg;
    assign rs_busy     = rs_busy_reg;
    assign rt_busy     = rt_busy_reg;
    assign pending_cnt = cnt_reg;
endmodule
